// File: rtl/phys_free_list_pkg.sv
// Shared core constants for physical-register bookkeeping.
// The free list and the RAT both take their reserved-register and reset-mapping layout from here.
package phys_free_list_pkg;

  localparam int unsigned CORE_ADDR_WIDTH = 5;
  // Physical registers 0 and 1 are never handed out.
  localparam int unsigned NUM_RSVD_PRS    = 2;
  // The RAT maps logical register n to physical register RAT_RESET_BASE+n out of reset.
  localparam int unsigned RAT_RESET_BASE  = 2;

  typedef enum logic [1:0] {
    FL_IDLE = 2'b00,
    FL_POP  = 2'b01,
    FL_PUSH = 2'b10,
    FL_BOTH = 2'b11
  } fl_op_e;

  function automatic int unsigned num_prs(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register numbers with zero-latency allocation.
// Define PHYS_FREE_LIST_CHECK_EN to drop and flag illegal or duplicate frees.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int unsigned NUM_LRS    = 10,
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  alloc_valid,
  input  logic                  alloc_ready,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  free_valid,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  free_ready,
  output logic [ADDR_WIDTH-1:0] free_count,
  output logic                  err
);

  localparam int unsigned NUM_PRS  = num_prs(ADDR_WIDTH);
  localparam int unsigned CAP      = NUM_PRS - NUM_RSVD_PRS;
  localparam int unsigned INIT_CNT = CAP - NUM_LRS;

  logic [ADDR_WIDTH-1:0] r_fifo [CAP];
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] w_head_nxt;
  logic [ADDR_WIDTH-1:0] w_tail_nxt;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  fl_op_e                w_op;

  assign alloc_valid = (r_count != '0);
  assign free_ready  = (r_count != ADDR_WIDTH'(CAP));
  assign free_count  = r_count;
  // No bypass: the head entry comes only from stored state.
  assign alloc_addr  = r_fifo[r_head];

  assign w_pop      = alloc_valid && alloc_ready;
  assign w_push_req = free_valid && free_ready;

  // CAP is not a power of two, so pointers wrap explicitly.
  assign w_head_nxt = (r_head == ADDR_WIDTH'(CAP - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == ADDR_WIDTH'(CAP - 1)) ? '0 : r_tail + 1'b1;

  assign w_op = fl_op_e'({w_push, w_pop});

`ifdef PHYS_FREE_LIST_CHECK_EN
  logic [NUM_PRS-1:0] r_inlist;
  logic               r_err;
  logic               w_legal;

  assign w_legal = (free_addr >= ADDR_WIDTH'(NUM_RSVD_PRS)) && !r_inlist[free_addr];
  assign w_push  = w_push_req && w_legal;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      for (int unsigned k = 0; k < NUM_PRS; k++) begin
        r_inlist[k] <= (k >= NUM_LRS + RAT_RESET_BASE);
      end
    end else begin
      if (w_push_req && !w_legal) r_err <= 1'b1;
      if (w_pop)  r_inlist[alloc_addr] <= 1'b0;
      if (w_push) r_inlist[free_addr]  <= 1'b1;
    end
  end
`else
  assign w_push = w_push_req;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= ADDR_WIDTH'(INIT_CNT);
      r_count <= ADDR_WIDTH'(INIT_CNT);
      for (int unsigned i = 0; i < CAP; i++) begin
        r_fifo[i] <= (i < INIT_CNT) ? ADDR_WIDTH'(NUM_LRS + RAT_RESET_BASE + i) : '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_tail] <= free_addr;
        r_tail         <= w_tail_nxt;
      end
      if (w_pop) r_head <= w_head_nxt;
      case (w_op)
        FL_POP:  r_count <= r_count - 1'b1;
        FL_PUSH: r_count <= r_count + 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list at default parameters.
// Follows PHYS_FREE_LIST_CHECK_EN so that expectations match the build under test.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [4:0] alloc_addr;
  logic       free_valid;
  logic [4:0] free_addr;
  logic       free_ready;
  logic [4:0] free_count;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phys_free_list #(.NUM_LRS(10), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_addr (alloc_addr),
    .free_valid (free_valid),
    .free_addr  (free_addr),
    .free_ready (free_ready),
    .free_count (free_count),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_addr   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    do_reset();
    got = {alloc_valid, alloc_addr, free_ready, err, 1'b0};
    n_vec++;
    if (got !== {1'b1, 5'd12, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: valid/addr/ready/err got %b, required %b", got, {1'b1, 5'd12, 1'b1, 1'b0, 1'b0});
    end
    n_vec++;
    if (free_count !== 5'd20) begin
      n_bad++;
      $display("FAIL reset_count: got %0d, required 20", free_count);
    end
  endtask

  task automatic test_drain();
    logic [4:0] exp;
    do_reset();
    alloc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp = 5'(12 + i);
      n_vec++;
      if (alloc_valid !== 1'b1 || alloc_addr !== exp) begin
        n_bad++;
        $display("FAIL drain_pop%0d: valid=%b addr=%0d, required valid=1 addr=%0d", i, alloc_valid, alloc_addr, exp);
      end
      tick();
    end
    n_vec++;
    if (alloc_valid !== 1'b0 || free_count !== 5'd0) begin
      n_bad++;
      $display("FAIL drain_empty: valid=%b count=%0d, required valid=0 count=0", alloc_valid, free_count);
    end
    // Held alloc_ready while empty must not underflow.
    tick();
    n_vec++;
    if (free_count !== 5'd0) begin
      n_bad++;
      $display("FAIL drain_no_underflow: count=%0d, required 0", free_count);
    end
  endtask

  task automatic test_empty_free();
    // Continues from the empty list left by test_drain.
    alloc_ready = 1'b1;
    free_valid  = 1'b1;
    free_addr   = 5'd7;
    n_vec++;
    if (alloc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_no_bypass: valid=%b, required 0", alloc_valid);
    end
    tick();
    free_valid  = 1'b0;
    alloc_ready = 1'b0;
    n_vec++;
    if (alloc_valid !== 1'b1 || alloc_addr !== 5'd7 || free_count !== 5'd1) begin
      n_bad++;
      $display("FAIL empty_free_visible: valid=%b addr=%0d count=%0d, required 1/7/1", alloc_valid, alloc_addr, free_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp;
    do_reset();
    alloc_ready = 1'b1;
    free_valid  = 1'b1;
    free_addr   = 5'd5;
    tick();
    free_valid = 1'b0;
    n_vec++;
    if (free_count !== 5'd20 || alloc_addr !== 5'd13) begin
      n_bad++;
      $display("FAIL simul_count: count=%0d head=%0d, required 20/13", free_count, alloc_addr);
    end
    for (int i = 0; i < 20; i++) begin
      exp = (i < 19) ? 5'(13 + i) : 5'd5;
      n_vec++;
      if (alloc_valid !== 1'b1 || alloc_addr !== exp) begin
        n_bad++;
        $display("FAIL simul_order%0d: valid=%b addr=%0d, required valid=1 addr=%0d", i, alloc_valid, alloc_addr, exp);
      end
      tick();
    end
    alloc_ready = 1'b0;
    n_vec++;
    if (alloc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_empty: valid=%b, required 0", alloc_valid);
    end
  endtask

  task automatic test_illegal_free();
    do_reset();
    free_valid = 1'b1;
    free_addr  = 5'd12;
    tick();
    free_addr  = 5'd0;
    tick();
    idle_inputs();
`ifdef PHYS_FREE_LIST_CHECK_EN
    n_vec++;
    if (free_count !== 5'd20 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_dropped: count=%0d err=%b, required 20/1", free_count, err);
    end
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_sticky: err=%b, required 1", err);
    end
`else
    n_vec++;
    if (free_count !== 5'd22 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL unchecked_accept: count=%0d err=%b, required 22/0", free_count, err);
    end
`endif
    do_reset();
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_reset_clears: err=%b, required 0", err);
    end
  endtask

  task automatic test_full_wrap();
    logic [4:0] exp;
    do_reset();
    free_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      free_addr = 5'(2 + i);
      tick();
    end
    free_valid = 1'b0;
    n_vec++;
    if (free_count !== 5'd30 || free_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_state: count=%0d ready=%b, required 30/0", free_count, free_ready);
    end
    free_valid = 1'b1;
    free_addr  = 5'd3;
    tick();
    free_valid = 1'b0;
    n_vec++;
    if (free_count !== 5'd30) begin
      n_bad++;
      $display("FAIL full_ignore: count=%0d, required 30", free_count);
    end
    // Pop all 30 to cross the head wrap point.
    alloc_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      exp = (i < 20) ? 5'(12 + i) : 5'(i - 18);
      n_vec++;
      if (alloc_valid !== 1'b1 || alloc_addr !== exp) begin
        n_bad++;
        $display("FAIL wrap_order%0d: valid=%b addr=%0d, required valid=1 addr=%0d", i, alloc_valid, alloc_addr, exp);
      end
      tick();
    end
    alloc_ready = 1'b0;
    n_vec++;
    if (free_count !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap_empty: count=%0d, required 0", free_count);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    alloc_ready = 1'b1;
    tick();
    tick();
    rst         = 1'b1;
    free_valid  = 1'b1;
    free_addr   = 5'd4;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_vec++;
    if (alloc_valid !== 1'b1 || alloc_addr !== 5'd12 || free_count !== 5'd20 || free_ready !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_priority: valid=%b addr=%0d count=%0d ready=%b err=%b, required 1/12/20/1/0",
               alloc_valid, alloc_addr, free_count, free_ready, err);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_drain();
    test_empty_free();
    test_simultaneous();
    test_illegal_free();
    test_full_wrap();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
